// File: rtl/uart_tx_arb.sv
// Two-client round-robin arbiter feeding a UART serializer, with start timeout and inter-frame gap.
// Latency: combinational accept in IDLE; tx_start one clk after accept.
// Backpressure: accepts only in IDLE with tx_busy low; clients hold valid/data until their ready pulse.
module uart_tx_arb #(
  parameter int unsigned GAP_BCLK = 1,
  parameter int unsigned START_TO = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bclk,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_din,
  output logic       grant_id,
  output logic       err_to
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    SEND,
    GAP
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(START_TO - 1);
  localparam logic [4:0] GAP_N   = 5'(GAP_BCLK);

  state_t     state, state_nxt;
  logic       arm;
  logic       last_gnt;
  logic       bclk_q;
  logic       busy_q;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic [3:0] to_cnt, to_cnt_nxt;
  logic       bclk_rise;
  logic       busy_fall;
  logic       accept;
  logic       sel;

  assign bclk_rise = bclk & ~bclk_q;
  assign busy_fall = busy_q & ~tx_busy;

  // On contention the client that did not win last time goes next.
  assign sel    = (req0_valid & req1_valid) ? ~last_gnt : req1_valid;
  // arm keeps readies low while rst_n is asserted, even if a client is already valid.
  assign accept = (state == IDLE) & arm & (req0_valid | req1_valid) & ~tx_busy;

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    to_cnt_nxt  = to_cnt;
    tx_start    = 1'b0;
    err_to      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req0_ready = ~sel;
          req1_ready = sel;
          state_nxt  = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start   = 1'b1;
        to_cnt_nxt = 4'd0;
        state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          to_cnt_nxt = 4'd0;
          state_nxt  = SEND;
        end else if (to_cnt == TO_LAST) begin
          // Serializer never picked the byte up: drop it and report.
          err_to     = 1'b1;
          to_cnt_nxt = 4'd0;
          state_nxt  = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 4'd1;
        end
      end
      SEND: begin
        if (busy_fall) begin
          gap_cnt_nxt = 4'd0;
          state_nxt   = (GAP_N == 5'd0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (bclk_rise) begin
          if (({1'b0, gap_cnt} + 5'd1) >= GAP_N) begin
            gap_cnt_nxt = 4'd0;
            state_nxt   = IDLE;
          end else begin
            gap_cnt_nxt = gap_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      arm      <= 1'b0;
      last_gnt <= 1'b1;
      grant_id <= 1'b0;
      tx_din   <= 8'h00;
      gap_cnt  <= 4'd0;
      to_cnt   <= 4'd0;
      bclk_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      arm     <= 1'b1;
      gap_cnt <= gap_cnt_nxt;
      to_cnt  <= to_cnt_nxt;
      bclk_q  <= bclk;
      busy_q  <= tx_busy;
      if (accept) begin
        tx_din   <= sel ? req1_data : req0_data;
        grant_id <= sel;
        last_gnt <= sel;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: default-gap instance plus a zero-gap instance sharing all inputs.
module tb_uart_tx_arb;

  logic       clk;
  logic       rst_n;
  logic       bclk;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       tx_busy;

  logic       req0_ready, req1_ready, tx_start, grant_id, err_to;
  logic [7:0] tx_din;
  logic       d0_req0_ready, d0_req1_ready, d0_tx_start, d0_grant_id, d0_err_to;
  logic [7:0] d0_tx_din;

  int checks = 0;
  int errors = 0;

  uart_tx_arb u_dut (
    .clk(clk), .rst_n(rst_n), .bclk(bclk),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_din(tx_din),
    .grant_id(grant_id), .err_to(err_to)
  );

  uart_tx_arb #(.GAP_BCLK(0), .START_TO(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bclk(bclk),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(d0_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(d0_req1_ready),
    .tx_busy(tx_busy), .tx_start(d0_tx_start), .tx_din(d0_tx_din),
    .grant_id(d0_grant_id), .err_to(d0_err_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset;
    rst_n      = 1'b0;
    bclk       = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    tx_busy    = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  // Entered in the LAUNCH cycle with inputs already set; returns in the first IDLE cycle
  // after exactly one bclk rise in GAP, before the caller sets that cycle's inputs.
  task automatic do_frame(input logic exp_gnt, input logic [7:0] exp_dat);
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL frame_tx_start: got %b expected 1", tx_start); end
    checks++; if (tx_din !== exp_dat) begin errors++; $display("FAIL frame_tx_din: got %h expected %h", tx_din, exp_dat); end
    checks++; if (grant_id !== exp_gnt) begin errors++; $display("FAIL frame_grant_id: got %b expected %b", grant_id, exp_gnt); end
    checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL frame_ready_launch: got %b%b expected 00", req0_ready, req1_ready); end
    step;
    tx_busy = 1'b1;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL frame_tx_start_once: got %b expected 0", tx_start); end
    step;
    step;
    step;
    tx_busy = 1'b0;
    #1;
    checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL frame_ready_send: got %b%b expected 00", req0_ready, req1_ready); end
    for (int i = 0; i < 3; i++) begin
      step;
      if (i == 2) bclk = 1'b1;
      #1;
      checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL frame_ready_gap%0d: got %b%b expected 00", i, req0_ready, req1_ready); end
    end
    step;
    bclk = 1'b0;
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    bclk       = 1'b0;
    tx_busy    = 1'b0;
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    req0_valid = 1'b1;
    req0_data  = 8'h5A;
    step;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b expected 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b expected 0", req1_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_din !== 8'h00) begin errors++; $display("FAIL reset_tx_din: got %h expected 00", tx_din); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %b expected 0", grant_id); end
    checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL reset_err_to: got %b expected 0", err_to); end
  endtask

  task automatic test_single;
    apply_reset;
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready: got %b expected 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready: got %b expected 0", req1_ready); end
    step;
    req0_valid = 1'b0;
    do_frame(1'b0, 8'hA5);
    #1;
    checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL single_idle_ready: got %b%b expected 00", req0_ready, req1_ready); end
    checks++; if (tx_din !== 8'hA5) begin errors++; $display("FAIL single_tx_din_hold: got %h expected a5", tx_din); end
  endtask

  task automatic test_round_robin;
    logic exp;
    apply_reset;
    req0_valid = 1'b1;
    req0_data  = 8'h11;
    req1_valid = 1'b1;
    req1_data  = 8'h22;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2) == 1;
      #1;
      checks++; if (req0_ready !== ~exp) begin errors++; $display("FAIL rr_req0_ready%0d: got %b expected %b", k, req0_ready, ~exp); end
      checks++; if (req1_ready !== exp) begin errors++; $display("FAIL rr_req1_ready%0d: got %b expected %b", k, req1_ready, exp); end
      step;
      do_frame(exp, exp ? 8'h22 : 8'h11);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_gap_entry;
    apply_reset;
    req0_valid = 1'b1;
    req0_data  = 8'h33;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL gapent_first_ready: got %b expected 1", req0_ready); end
    step;
    req0_valid = 1'b0;
    do_frame(1'b0, 8'h33);
    req1_valid = 1'b1;
    req1_data  = 8'h44;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL gapent_req1_ready: got %b expected 1", req1_ready); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL gapent_req0_ready: got %b expected 0", req0_ready); end
    step;
    req1_valid = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL gapent_tx_start: got %b expected 1", tx_start); end
    checks++; if (tx_din !== 8'h44) begin errors++; $display("FAIL gapent_tx_din: got %h expected 44", tx_din); end
  endtask

  task automatic test_timeout;
    apply_reset;
    req0_valid = 1'b1;
    req0_data  = 8'h55;
    req1_valid = 1'b1;
    req1_data  = 8'h66;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL to_first_grant: got %b expected 1", req0_ready); end
    step;
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_tx_start: got %b expected 1", tx_start); end
    for (int i = 1; i <= 4; i++) begin
      step;
      #1;
      checks++; if (err_to !== (i == 4)) begin errors++; $display("FAIL to_err_to_c%0d: got %b expected %b", i, err_to, (i == 4)); end
      checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL to_ready_c%0d: got %b%b expected 00", i, req0_ready, req1_ready); end
    end
    step;
    #1;
    checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL to_err_to_once: got %b expected 0", err_to); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL to_next_req1_ready: got %b expected 1", req1_ready); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL to_next_req0_ready: got %b expected 0", req0_ready); end
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checks++; if (tx_din !== 8'h66) begin errors++; $display("FAIL to_next_tx_din: got %h expected 66", tx_din); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL to_next_grant: got %b expected 1", grant_id); end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    req1_valid = 1'b1;
    req1_data  = 8'h77;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_req1_ready: got %b expected 1", req1_ready); end
    step;
    req1_valid = 1'b0;
    step;
    tx_busy = 1'b1;
    step;
    req0_valid = 1'b1;
    req0_data  = 8'h88;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_din !== 8'h00) begin errors++; $display("FAIL rmid_tx_din: got %h expected 00", tx_din); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rmid_grant_id: got %b expected 0", grant_id); end
    checks++; if ((req0_ready | req1_ready | tx_start | err_to) !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got r0=%b r1=%b start=%b err=%b expected all 0", req0_ready, req1_ready, tx_start, err_to); end
    step;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      #1;
      checks++; if ((req0_ready | req1_ready | tx_start) !== 1'b0) begin errors++; $display("FAIL rmid_blocked%0d: got r0=%b r1=%b start=%b expected 0", i, req0_ready, req1_ready, tx_start); end
    end
    step;
    tx_busy = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_resume_ready: got %b expected 1", req0_ready); end
    step;
    req0_valid = 1'b0;
    #1;
    checks++; if (tx_din !== 8'h88) begin errors++; $display("FAIL rmid_resume_tx_din: got %h expected 88", tx_din); end
  endtask

  task automatic test_gap_zero;
    apply_reset;
    req0_valid = 1'b1;
    req0_data  = 8'h99;
    #1;
    checks++; if (d0_req0_ready !== 1'b1) begin errors++; $display("FAIL gap0_first_ready: got %b expected 1", d0_req0_ready); end
    step;
    #1;
    checks++; if (d0_tx_start !== 1'b1) begin errors++; $display("FAIL gap0_tx_start: got %b expected 1", d0_tx_start); end
    step;
    tx_busy = 1'b1;
    step;
    step;
    step;
    tx_busy = 1'b0;
    #1;
    checks++; if (d0_req0_ready !== 1'b0) begin errors++; $display("FAIL gap0_ready_send: got %b expected 0", d0_req0_ready); end
    step;
    #1;
    checks++; if (d0_req0_ready !== 1'b1) begin errors++; $display("FAIL gap0_next_ready: got %b expected 1", d0_req0_ready); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL gap1_still_gap: got %b expected 0", req0_ready); end
    step;
    req0_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_gap_entry;
    test_timeout;
    test_reset_mid;
    test_gap_zero;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
